// File: rtl/sum_accumulator.sv
// Sums COUNT adder results per group and presents the total with a sticky overflow flag.
// Result is valid the cycle after the final input; held in HOLD (in_ready low) until out_ready.
module sum_accumulator #(
  parameter int IN_WIDTH  = 4,
  parameter int COUNT     = 4,
  parameter int OUT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  in_sum,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_total,
  output logic                 out_overflow,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CNT_W = ($clog2(COUNT) > 1) ? $clog2(COUNT) : 1;
  localparam int SUM_W = OUT_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state_q, state_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SUM_W-1:0]     sum_ext;

  // One extra bit so the carry out of the running total is visible.
  assign sum_ext = {1'b0, acc_q} + SUM_W'(in_sum);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum_ext[OUT_WIDTH-1:0];
          ovf_d = ovf_q | sum_ext[OUT_WIDTH];
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Handshake outputs decode the state register only; no input-to-output paths.
  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == HOLD);
  assign out_total    = acc_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed vectors for sum_accumulator; a queue-based scoreboard checks every output transfer.
module tb_sum_accumulator;

  typedef struct packed {
    logic [5:0] tot;
    logic       ovf;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [1:0][3:0] in_sum;
  logic [1:0]      in_valid;
  logic [1:0]      in_ready;
  logic [1:0]      out_valid;
  logic [1:0]      out_ready;
  logic [1:0]      out_overflow;
  logic [5:0]      out_total_a;
  logic [4:0]      out_total_b;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   nvec  = 0;
  int   nfail = 0;

  sum_accumulator dut_a (
    .clk(clk), .reset(reset),
    .in_sum(in_sum[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_total(out_total_a), .out_overflow(out_overflow[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0])
  );

  sum_accumulator #(.IN_WIDTH(4), .COUNT(3), .OUT_WIDTH(5)) dut_b (
    .clk(clk), .reset(reset),
    .in_sum(in_sum[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_total(out_total_b), .out_overflow(out_overflow[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output transfer happens at the next rising edge when valid & ready are seen here.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid[0] && out_ready[0]) begin
      if (exp_a.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL a_unexpected: got total %0d with no result pending", out_total_a);
      end else begin
        e = exp_a.pop_front();
        chk("a_total", int'(out_total_a), int'(e.tot));
        chk("a_ovf", int'(out_overflow[0]), int'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid[1] && out_ready[1]) begin
      if (exp_b.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL b_unexpected: got total %0d with no result pending", out_total_b);
      end else begin
        e = exp_b.pop_front();
        chk("b_total", int'(out_total_b), int'(e.tot));
        chk("b_ovf", int'(out_overflow[1]), int'(e.ovf));
      end
    end
  end

  // Offers one sum to DUT d; returns #1 after the accepting edge.
  task automatic send(input int d, input logic [3:0] v);
    logic rdy;
    int   n;
    n = 0;
    in_valid[d] = 1'b1;
    in_sum[d]   = v;
    forever begin
      @(negedge clk);
      rdy = in_ready[d];
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        nvec++; nfail++;
        $display("FAIL send_timeout: dut %0d never ready, got in_ready 0, expected 1", d);
        break;
      end
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_sum    = '0;
    out_ready = '0;
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready[0]), 1);
    chk("rst_out_valid", int'(out_valid[0]), 0);
    chk("rst_total", int'(out_total_a), 0);
    chk("rst_ovf", int'(out_overflow[0]), 0);
    reset     = 1'b0;
    out_ready = 2'b11;

    // Basic group and latency
    exp_a.push_back('{tot: 6'd16, ovf: 1'b0});
    send(0, 4'd3); send(0, 4'd5); send(0, 4'd7); send(0, 4'd1);
    chk("basic_valid_next", int'(out_valid[0]), 1);
    chk("basic_in_ready_hold", int'(in_ready[0]), 0);
    tick();
    chk("basic_in_ready_again", int'(in_ready[0]), 1);
    chk("basic_valid_clear", int'(out_valid[0]), 0);

    // Maximum inputs
    exp_a.push_back('{tot: 6'd60, ovf: 1'b0});
    send(0, 4'd15); send(0, 4'd15); send(0, 4'd15); send(0, 4'd15);
    tick();

    // Backpressure with a pending input of 9
    out_ready[0] = 1'b0;
    exp_a.push_back('{tot: 6'd10, ovf: 1'b0});
    send(0, 4'd1); send(0, 4'd2); send(0, 4'd3); send(0, 4'd4);
    in_valid[0] = 1'b1;
    in_sum[0]   = 4'd9;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", int'(out_valid[0]), 1);
      chk("bp_total", int'(out_total_a), 10);
      chk("bp_ovf", int'(out_overflow[0]), 0);
      chk("bp_in_ready", int'(in_ready[0]), 0);
      tick();
    end
    out_ready[0] = 1'b1;
    tick();
    chk("bp_release_in_ready", int'(in_ready[0]), 1);
    chk("bp_release_valid", int'(out_valid[0]), 0);
    exp_a.push_back('{tot: 6'd12, ovf: 1'b0});
    send(0, 4'd9); send(0, 4'd1); send(0, 4'd1); send(0, 4'd1);
    tick();

    // Input gaps
    exp_a.push_back('{tot: 6'd20, ovf: 1'b0});
    send(0, 4'd2);
    tick(); tick();
    send(0, 4'd4);
    tick();
    send(0, 4'd6); send(0, 4'd8);
    tick();

    // Reset mid-group; the input offered during reset must be ignored
    send(0, 4'd7); send(0, 4'd7);
    in_valid[0] = 1'b1;
    in_sum[0]   = 4'd15;
    pulse_reset();
    in_valid[0] = 1'b0;
    exp_a.push_back('{tot: 6'd10, ovf: 1'b0});
    send(0, 4'd1); send(0, 4'd2); send(0, 4'd3); send(0, 4'd4);
    tick();

    // Reset while holding a result: it is dropped
    out_ready[0] = 1'b0;
    send(0, 4'd5); send(0, 4'd5); send(0, 4'd5); send(0, 4'd5);
    chk("rhold_valid_before", int'(out_valid[0]), 1);
    chk("rhold_total_before", int'(out_total_a), 20);
    pulse_reset();
    chk("rhold_valid", int'(out_valid[0]), 0);
    chk("rhold_total", int'(out_total_a), 0);
    chk("rhold_ovf", int'(out_overflow[0]), 0);
    chk("rhold_in_ready", int'(in_ready[0]), 1);
    out_ready[0] = 1'b1;
    exp_a.push_back('{tot: 6'd4, ovf: 1'b0});
    send(0, 4'd1); send(0, 4'd1); send(0, 4'd1); send(0, 4'd1);
    tick();

    // Overflow on the narrow instance, then flag clears for the next group
    exp_b.push_back('{tot: 6'd13, ovf: 1'b1});
    send(1, 4'd15); send(1, 4'd15); send(1, 4'd15);
    chk("ovf_valid", int'(out_valid[1]), 1);
    exp_b.push_back('{tot: 6'd3, ovf: 1'b0});
    send(1, 4'd1); send(1, 4'd1); send(1, 4'd1);
    tick();
    tick();

    chk("a_results_drained", exp_a.size(), 0);
    chk("b_results_drained", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
